// File: rtl/bus_arbiter_m2.sv
// Two-master bus arbiter with round-robin tie-break, per-tenure timeout and
// lockout of a timed-out master until it drops its request.
//
// state    | meaning
// IDLE     | no owner; arbitrate when all slaves are ready
// GRANT1   | master 1 owns the bus
// GRANT2   | master 2 owns the bus
// HANDOVER | one dead cycle between owners
module bus_arbiter_m2 #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_WIDTH      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_breq,
  input  logic       m2_breq,
  input  logic [2:0] s_ready,
  output logic       m1_bgrant,
  output logic       m2_bgrant,
  output logic       msel,
  output logic       bus_busy,
  output logic       timeout,
  output logic       timeout_id
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, HANDOVER} state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // Counter holds (cycles granted - 1), so the limit is reached one below TIMEOUT_CYCLES.
  localparam logic [CNT_WIDTH-1:0] TC_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] tenure_cnt, tenure_cnt_nxt;
  logic                 lock1, lock2, lock1_nxt, lock2_nxt;
  logic                 last_m2, last_m2_nxt;
  logic                 msel_nxt, timeout_nxt, timeout_id_nxt;
  logic                 elig1, elig2;

  assign elig1 = m1_breq & ~lock1;
  assign elig2 = m2_breq & ~lock2;

  always_comb begin
    state_nxt      = state;
    tenure_cnt_nxt = tenure_cnt;
    last_m2_nxt    = last_m2;
    msel_nxt       = msel;
    timeout_nxt    = 1'b0;
    timeout_id_nxt = timeout_id;
    lock1_nxt      = lock1 & m1_breq;
    lock2_nxt      = lock2 & m2_breq;

    case (state)
      IDLE: begin
        if (s_ready == 3'b111) begin
          if (elig1 && (!elig2 || last_m2)) begin
            state_nxt      = GRANT1;
            tenure_cnt_nxt = '0;
            last_m2_nxt    = 1'b0;
            msel_nxt       = 1'b0;
          end else if (elig2) begin
            state_nxt      = GRANT2;
            tenure_cnt_nxt = '0;
            last_m2_nxt    = 1'b1;
            msel_nxt       = 1'b1;
          end
        end
      end
      GRANT1: begin
        // A release on the timeout edge wins over the timeout.
        if (!m1_breq) begin
          state_nxt = HANDOVER;
        end else if (TMO_EN && tenure_cnt == TC_LAST) begin
          state_nxt      = HANDOVER;
          timeout_nxt    = 1'b1;
          timeout_id_nxt = 1'b0;
          lock1_nxt      = 1'b1;
        end else begin
          tenure_cnt_nxt = tenure_cnt + CNT_WIDTH'(1);
        end
      end
      GRANT2: begin
        if (!m2_breq) begin
          state_nxt = HANDOVER;
        end else if (TMO_EN && tenure_cnt == TC_LAST) begin
          state_nxt      = HANDOVER;
          timeout_nxt    = 1'b1;
          timeout_id_nxt = 1'b1;
          lock2_nxt      = 1'b1;
        end else begin
          tenure_cnt_nxt = tenure_cnt + CNT_WIDTH'(1);
        end
      end
      HANDOVER: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tenure_cnt <= '0;
      lock1      <= 1'b0;
      lock2      <= 1'b0;
      last_m2    <= 1'b1;
      m1_bgrant  <= 1'b0;
      m2_bgrant  <= 1'b0;
      bus_busy   <= 1'b0;
      msel       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= 1'b0;
    end else begin
      state      <= state_nxt;
      tenure_cnt <= tenure_cnt_nxt;
      lock1      <= lock1_nxt;
      lock2      <= lock2_nxt;
      last_m2    <= last_m2_nxt;
      m1_bgrant  <= (state_nxt == GRANT1);
      m2_bgrant  <= (state_nxt == GRANT2);
      bus_busy   <= (state_nxt == GRANT1) || (state_nxt == GRANT2);
      msel       <= msel_nxt;
      timeout    <= timeout_nxt;
      timeout_id <= timeout_id_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_m2.sv
// Bench for bus_arbiter_m2: directed scenarios pinned to literals, then random
// traffic checked every cycle against an owner/cycle-count reference model.
module tb_bus_arbiter_m2;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m1_breq = 1'b0;
  logic       m2_breq = 1'b0;
  logic [2:0] s_ready = 3'b111;
  logic       m1_bgrant, m2_bgrant, msel, bus_busy, timeout, timeout_id;

  bus_arbiter_m2 #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .m1_breq(m1_breq), .m2_breq(m2_breq), .s_ready(s_ready),
    .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant), .msel(msel), .bus_busy(bus_busy),
    .timeout(timeout), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model: who owns the bus, for how many cycles, and dead cycles left.
  int owner = 0;
  int held = 0;
  int cool = 0;
  bit lk1 = 0, lk2 = 0, last2 = 1;
  bit e_msel = 0, e_to = 0, e_tid = 0;

  task automatic model_step();
    bit r1, r2, nl1, nl2, rq, el1, el2;
    if (rst) begin
      owner = 0; held = 0; cool = 0; lk1 = 0; lk2 = 0; last2 = 1;
      e_msel = 0; e_to = 0; e_tid = 0;
      return;
    end
    r1 = m1_breq; r2 = m2_breq;
    nl1 = lk1 & r1; nl2 = lk2 & r2;
    e_to = 0;
    if (owner != 0) begin
      rq = (owner == 1) ? r1 : r2;
      if (!rq) begin
        owner = 0; cool = 1;
      end else if (TMO != 0 && held == TMO) begin
        e_to = 1; e_tid = (owner == 2);
        if (owner == 1) nl1 = 1; else nl2 = 1;
        owner = 0; cool = 1;
      end else held++;
    end else if (cool > 0) begin
      cool--;
    end else if (s_ready == 3'b111) begin
      el1 = r1 && !lk1; el2 = r2 && !lk2;
      if (el1 && el2) owner = last2 ? 1 : 2;
      else if (el1) owner = 1;
      else if (el2) owner = 2;
      if (owner != 0) begin
        held = 1; last2 = (owner == 2); e_msel = (owner == 2);
      end
    end
    lk1 = nl1; lk2 = nl2;
  endtask

  task automatic cmp(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m1_bgrant", m1_bgrant, owner == 1);
      cmp("m2_bgrant", m2_bgrant, owner == 2);
      cmp("bus_busy", bus_busy, owner != 0);
      cmp("msel", msel, e_msel);
      cmp("timeout", timeout, e_to);
      cmp("timeout_id", timeout_id, e_tid);
      cmp("grant_exclusive", m1_bgrant & m2_bgrant, 1'b0);
    end
  end

  // Literal expectations, checked against both the DUT and the model.
  task automatic pin(string nm, bit g1, bit g2, bit ms, bit to, bit tid);
    cmp({nm, ".g1"}, m1_bgrant, g1);
    cmp({nm, ".g2"}, m2_bgrant, g2);
    cmp({nm, ".msel"}, msel, ms);
    cmp({nm, ".timeout"}, timeout, to);
    cmp({nm, ".tid"}, timeout_id, tid);
    cmp({nm, ".model_g1"}, owner == 1, g1);
    cmp({nm, ".model_g2"}, owner == 2, g2);
    cmp({nm, ".model_to"}, e_to, to);
  endtask

  task automatic tick(bit r, bit b1, bit b2, logic [2:0] rdy);
    rst = r; m1_breq = b1; m2_breq = b2; s_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    bit b1, b2, r;
    logic [2:0] rdy;
    chk_en = 1;

    // single request, release on the 4th grant cycle (normal release, no timeout)
    tick(1, 0, 0, 3'b111); pin("reset", 0, 0, 0, 0, 0);
    tick(0, 1, 0, 3'b111); pin("m1_grant", 1, 0, 0, 0, 0);
    repeat (3) tick(0, 1, 0, 3'b111);
    pin("m1_hold", 1, 0, 0, 0, 0);
    tick(0, 0, 0, 3'b111); pin("m1_release", 0, 0, 0, 0, 0);
    tick(0, 0, 0, 3'b111); pin("handover", 0, 0, 0, 0, 0);

    // tie resolution and alternation
    tick(1, 0, 0, 3'b111);
    tick(0, 1, 1, 3'b111); pin("tie_first", 1, 0, 0, 0, 0);
    tick(0, 1, 1, 3'b111);
    tick(0, 0, 1, 3'b111); pin("tie_rel", 0, 0, 0, 0, 0);
    tick(0, 0, 1, 3'b111); pin("tie_gap", 0, 0, 0, 0, 0);
    tick(0, 1, 1, 3'b111); pin("tie_second", 0, 1, 1, 0, 0);
    tick(0, 1, 0, 3'b111);
    tick(0, 1, 0, 3'b111);
    tick(0, 1, 1, 3'b111); pin("tie_third", 1, 0, 0, 0, 0);
    tick(0, 0, 0, 3'b111);
    tick(0, 0, 0, 3'b111);

    // timeout and lockout of master 2
    tick(1, 0, 0, 3'b111);
    tick(0, 0, 1, 3'b111); pin("m2_grant", 0, 1, 1, 0, 0);
    repeat (3) tick(0, 0, 1, 3'b111);
    pin("m2_hold4", 0, 1, 1, 0, 0);
    tick(0, 0, 1, 3'b111); pin("m2_timeout", 0, 0, 1, 1, 1);
    tick(0, 0, 1, 3'b111); pin("to_pulse_end", 0, 0, 1, 0, 1);
    repeat (3) tick(0, 0, 1, 3'b111);
    pin("m2_locked", 0, 0, 1, 0, 1);
    tick(0, 0, 0, 3'b111);
    tick(0, 0, 1, 3'b111); pin("m2_regrant", 0, 1, 1, 0, 1);
    tick(0, 0, 0, 3'b111);
    tick(0, 0, 0, 3'b111);

    // slaves not ready
    tick(1, 0, 0, 3'b111);
    repeat (3) tick(0, 1, 0, 3'b101);
    pin("not_ready", 0, 0, 0, 0, 0);
    tick(0, 1, 0, 3'b111); pin("ready_grant", 1, 0, 0, 0, 0);
    tick(0, 1, 0, 3'b000); pin("ready_drop_hold", 1, 0, 0, 0, 0);
    tick(0, 0, 0, 3'b111);

    // reset mid-tenure
    tick(1, 0, 0, 3'b111);
    tick(0, 0, 1, 3'b111); pin("pre_rst", 0, 1, 1, 0, 0);
    tick(1, 0, 1, 3'b111); pin("mid_rst", 0, 0, 0, 0, 0);
    tick(0, 1, 1, 3'b111); pin("post_rst_tie", 1, 0, 0, 0, 0);

    // random traffic
    b1 = 0; b2 = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) b1 = ~b1;
      if ($urandom_range(0, 5) == 0) b2 = ~b2;
      rdy = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom);
      tick(r, b1, b2, rdy);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_m2.md
BUS_ARBITER_M2 -- requirements
Module: bus_arbiter_m2

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, maximum cycles a master holds the grant per tenure; 0 disables the timeout.
REQ-002 Parameter: CNT_WIDTH, default 10, tenure counter width; TIMEOUT_CYCLES SHALL be at most 2^CNT_WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m1_breq  input  1  master 1 bus request, level, held for the whole transaction.
REQ-006 m2_breq  input  1  master 2 bus request, level.
REQ-007 s_ready  input  3  per-slave ready, bit0=slave1, bit2=slave3.
REQ-008 m1_bgrant  output  1  master 1 owns the bus.
REQ-009 m2_bgrant  output  1  master 2 owns the bus.
REQ-010 msel  output  1  bus mux select, 0=master1, 1=master2.
REQ-011 bus_busy  output  1  high while either grant is high.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
REQ-013 timeout_id  output  1  master revoked by the most recent timeout, 0=master1, 1=master2.

Function
REQ-014 All outputs SHALL be registered; m1_bgrant and m2_bgrant SHALL never be high in the same cycle.
REQ-015 FSM states: IDLE, GRANT1, GRANT2, HANDOVER; reset state IDLE.
REQ-016 IDLE: grant only if s_ready==3'b111 and an eligible request is sampled; the grant goes high in the cycle after the edge that samples the request (1-cycle latency).
REQ-017 Eligible means breq high and the master's lockout bit clear.
REQ-018 Both eligible in IDLE: grant the master not granted last (round-robin pointer); after reset the pointer marks master2 as last, so master1 wins the first tie.
REQ-019 One eligible: grant it regardless of the pointer.
REQ-020 On grant: msel SHALL update to the granted master in the same cycle the grant rises; the pointer SHALL update to the granted master.
REQ-021 In IDLE, HANDOVER and after a grant falls, msel SHALL hold its value.
REQ-022 GRANTn: hold the grant while mn_breq is sampled high; s_ready changes and the other master's breq SHALL be ignored.
REQ-023 GRANTn with mn_breq sampled low: go to HANDOVER, with the grant low from the next cycle.
REQ-024 HANDOVER lasts exactly one cycle with both grants low, then IDLE; a release at edge N gives the earliest next grant after edge N+2.
REQ-025 Tenure counter: clears on entry to GRANTn and increments each cycle in GRANTn.
REQ-026 Timeout: if TIMEOUT_CYCLES!=0 and the grant has been high for TIMEOUT_CYCLES cycles with breq still high, drop the grant, go to HANDOVER, pulse timeout for one cycle, write timeout_id, and set that master's lockout bit.
REQ-027 Lockout bit clears at the edge where its master's breq is sampled low; a locked master SHALL not be granted.
REQ-028 Simultaneous: if breq falls on the same edge the timeout would fire, treat it as a normal release, with no timeout pulse and no lockout.
REQ-029 Requests arriving during HANDOVER SHALL be evaluated in IDLE on the following edge.
REQ-030 s_ready not all high in IDLE: stay in IDLE, grants low, requests stay pending.

Reset
REQ-031 rst sampled high SHALL force IDLE within one edge, including mid-tenure.
REQ-032 Reset values: both grants 0, bus_busy 0, msel 0, timeout 0, timeout_id 0, counter 0, both lockouts 0, pointer=master2.

Verification
REQ-033 Reset, s_ready=111, m1_breq=1 at edge 0 -> m1_bgrant=1 and msel=0 after edge 1; m1_breq=0 at edge 5 -> grant low after edge 5, HANDOVER for one cycle, IDLE.
REQ-034 Both breq rise together after reset -> master1 is granted first; after master1 releases, master2 is granted 2 edges later with msel=1; repeat, and grants alternate.
REQ-035 TIMEOUT_CYCLES=4, m2 holds breq -> grant high for exactly 4 cycles, timeout pulses once, timeout_id=1; m2 is not regranted until m2_breq drops and rises again.
REQ-036 s_ready=101 with m1_breq=1 -> no grant; s_ready goes to 111 -> grant one edge later; s_ready drops mid-tenure -> grant held.
REQ-037 rst pulsed mid-tenure for master2 -> after the reset edge, grants are 0, msel=0, and the pointer is reset (master1 wins the next tie).
REQ-038 TIMEOUT_CYCLES=4, breq falls on the 4th grant cycle -> normal release, timeout stays 0, no lockout.
